// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, shadow-register type and helpers for the PWM generator.
// No ports; imported by pwm_ch and pwm_gen4.
package pwm_pkg;
    localparam int          PWM_STEPS    = 100;
    localparam int          PWM_FREQ_W   = 16;
    localparam int          PWM_DUTY_W   = 7;
    localparam logic [15:0] PWM_FREQ_RST = 16'd100;
    localparam logic [6:0]  PWM_DUTY_MAX = 7'd100;

    typedef struct packed {
        logic [PWM_FREQ_W-1:0] freq;
        logic [PWM_DUTY_W-1:0] duty;
    } pwm_cfg_t;

    // A frequency setting of 0 would never wrap the tick counter, so it runs as 1.
    function automatic logic [PWM_FREQ_W-1:0] freq_eff(input logic [PWM_FREQ_W-1:0] f);
        return (f == '0) ? PWM_FREQ_W'(1) : f;
    endfunction

    function automatic logic [PWM_DUTY_W-1:0] duty_clamp(input logic [PWM_DUTY_W-1:0] d);
        return (d > PWM_DUTY_MAX) ? PWM_DUTY_MAX : d;
    endfunction
endpackage

// File: rtl/pwm_ch.sv
// pwm_ch: one PWM channel with tick/step counters and double-buffered settings.
// Ports: i_clk clock, i_rst_n async active-low reset, i_freq clocks per step,
//        i_duty duty in percent, o_pwm PWM output, o_sync one-clock period-start pulse.
module pwm_ch
    import pwm_pkg::*;
#(
    parameter int STEPS = PWM_STEPS
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [PWM_FREQ_W-1:0] i_freq,
    input  logic [PWM_DUTY_W-1:0] i_duty,
    output logic                  o_pwm,
    output logic                  o_sync
);
    pwm_cfg_t              r_sh;
    logic [PWM_FREQ_W-1:0] r_tick;
    logic [PWM_DUTY_W-1:0] r_step;
    logic                  r_pwm;
    logic                  r_sync;

    logic [PWM_FREQ_W-1:0] w_feff;
    logic                  w_tick_wrap;
    logic                  w_bound;
    logic [PWM_FREQ_W-1:0] w_tick_next;
    logic [PWM_DUTY_W-1:0] w_step_next;
    pwm_cfg_t              w_sh_next;

    always_comb begin
        w_feff      = freq_eff(r_sh.freq);
        w_tick_wrap = (r_tick == w_feff - PWM_FREQ_W'(1));
        w_bound     = w_tick_wrap && (r_step == PWM_DUTY_W'(STEPS - 1));
        w_tick_next = w_tick_wrap ? '0 : r_tick + PWM_FREQ_W'(1);
        w_step_next = !w_tick_wrap ? r_step : w_bound ? '0 : r_step + PWM_DUTY_W'(1);
        // Shadows reload only on the period boundary, from inputs sampled at that edge.
        w_sh_next   = w_bound ? pwm_cfg_t'{freq: i_freq, duty: duty_clamp(i_duty)} : r_sh;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick <= '0;
            r_step <= '0;
            r_sh   <= pwm_cfg_t'{freq: PWM_FREQ_RST, duty: '0};
            r_pwm  <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_tick <= w_tick_next;
            r_step <= w_step_next;
            r_sh   <= w_sh_next;
            // Computed from next-state values so the flop lines up with the counters.
            r_pwm  <= (w_step_next < w_sh_next.duty);
            r_sync <= w_bound;
        end
    end

    assign o_pwm  = r_pwm;
    assign o_sync = r_sync;
endmodule

// File: rtl/pwm_gen4.sv
// pwm_gen4: four independent PWM channels mapped onto per-channel ports.
// Ports: clock, reset (async active-low), pwm_freq1..4 clocks per step,
//        pwm_duty1..4 duty in percent, pwm_out[N-1] / pwm_sync[N-1] for channel N.
module pwm_gen4
    import pwm_pkg::*;
#(
    parameter int STEPS = PWM_STEPS,
    parameter int NCH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PWM_FREQ_W-1:0] pwm_freq1,
    input  logic [PWM_FREQ_W-1:0] pwm_freq2,
    input  logic [PWM_FREQ_W-1:0] pwm_freq3,
    input  logic [PWM_FREQ_W-1:0] pwm_freq4,
    input  logic [PWM_DUTY_W-1:0] pwm_duty1,
    input  logic [PWM_DUTY_W-1:0] pwm_duty2,
    input  logic [PWM_DUTY_W-1:0] pwm_duty3,
    input  logic [PWM_DUTY_W-1:0] pwm_duty4,
    output logic [NCH-1:0]        pwm_out,
    output logic [NCH-1:0]        pwm_sync
);
    logic [PWM_FREQ_W-1:0] w_freq [NCH];
    logic [PWM_DUTY_W-1:0] w_duty [NCH];

    assign w_freq[0] = pwm_freq1;
    assign w_freq[1] = pwm_freq2;
    assign w_freq[2] = pwm_freq3;
    assign w_freq[3] = pwm_freq4;
    assign w_duty[0] = pwm_duty1;
    assign w_duty[1] = pwm_duty2;
    assign w_duty[2] = pwm_duty3;
    assign w_duty[3] = pwm_duty4;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_ch #(.STEPS(STEPS)) u_ch (
            .i_clk   (clock),
            .i_rst_n (reset),
            .i_freq  (w_freq[i]),
            .i_duty  (w_duty[i]),
            .o_pwm   (pwm_out[i]),
            .o_sync  (pwm_sync[i])
        );
    end
endmodule

// File: doc/pwm_gen4.md
Name: pwm_gen4

Overview:
Four-channel PWM generator that consumes the per-channel frequency and duty settings held in the peripheral register block.
- Each channel produces one output, with period = 100 steps × pwm_freqN clocks.
- High time = pwm_dutyN steps; duty is in percent.
- Settings are double-buffered and applied only at period boundaries, so outputs never glitch when software rewrites a register.

Parameters:
STEPS, 100, steps per PWM period (duty resolution in percent)
NCH, 4, number of channels (fixed at 4; the port list is per channel)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
pwm_freq1..pwm_freq4  in  16 each  clocks per duty step for channel N; 0 is treated as 1
pwm_duty1..pwm_duty4  in  7 each  duty in percent for channel N; values >100 clamp to 100
pwm_out  out  4  PWM outputs; bit N-1 = channel N
pwm_sync  out  4  one-clock pulse on the first clock of each new period, per channel

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All state is cleared the instant reset goes low, and stays cleared while it is low.
- Per-channel state:
  - tick_cnt[15:0]
  - step_cnt[6:0], range 0..99
  - freq_sh[15:0], shadow
  - duty_sh[6:0], shadow
  - pwm_out bit, pwm_sync bit
- Reset values:
  - tick_cnt = 0, step_cnt = 0
  - freq_sh = 100, duty_sh = 0
  - pwm_out = 0, pwm_sync = 0
- Effective values:
  - f_eff = (freq_sh == 0) ? 1 : freq_sh
  - In-range inputs: duty_in_eff = min(pwm_dutyN, 100)
- Tick counter, each clock:
  - If tick_cnt == f_eff-1: tick_cnt <= 0 and the step advances.
  - Otherwise tick_cnt <= tick_cnt+1.
- Step advance:
  - If step_cnt == STEPS-1, this is a period boundary: step_cnt <= 0.
  - Otherwise step_cnt <= step_cnt+1.
- Period boundary, on the same edge:
  - freq_sh <= pwm_freqN.
  - duty_sh <= duty_in_eff, using the input values sampled at that edge.
  - pwm_sync <= 1 for exactly one clock; otherwise pwm_sync <= 0.
- Output:
  - pwm_out is a flop computed from next-state values: pwm_out <= (step_next < duty_next).
  - The output is therefore exactly aligned with the registered counters: pwm_out == (step_cnt < duty_sh) every cycle after the first.
- Resulting timing per period:
  - Period = 100 × f_eff clocks.
  - High time = duty_sh × f_eff clocks, starting on the sync cycle.
  - duty 0 → constantly low; duty ≥100 → constantly high, with no low pulse at the boundary.
- Mid-period input changes: ignored until the next boundary. Comparisons always use the shadows.
- Input changing on the exact boundary edge: the new value is captured and takes effect in the period that starts at that edge.
- First period after reset uses the reset shadows (f=100, duty=0):
  - Output low for 10000 clocks.
  - New register values load at clock 10000 and pwm_sync pulses then.
  - No sync pulse is generated on reset release.
- Channels are fully independent; there is no shared counter.
- Arithmetic: all counters are unsigned. tick_cnt never exceeds 65534. step_cnt never exceeds 99.

Decomposition:
- Shared package pwm_pkg: PWM_STEPS=100, PWM_FREQ_W=16, PWM_DUTY_W=7, PWM_FREQ_RST=16'd100, PWM_DUTY_MAX=7'd100.
- Sub-module pwm_ch (one channel):
  - Contains tick/step counters, shadows, clamp, output and sync flops.
  - Instantiated four times by pwm_gen4, which only maps ports.

Test Plan:
1. Reset defaults: hold reset low → pwm_out=0, pwm_sync=0. Release with inputs 100/0 → output stays low; first sync at clock 10000 after release.
2. freq1=2, duty1=50 applied before first boundary:
   - Next period is 200 clocks.
   - pwm_out[0] high for 100 clocks, starting on the pwm_sync[0] cycle.
   - Sync pulses are 200 clocks apart.
3. Duty extremes, freq=1:
   - duty=0 → always low.
   - duty=100 → always high across boundaries, with no glitch.
   - duty=127 → identical to 100.
   - duty=1 → high 1 clock per 100.
4. Mid-period update: freq=3, duty=20 running, change to duty=70 at step 40 → current period keeps a 60-clock high time; the next period has a 210-clock high time.
5. freq=0, duty=30 → period 100 clocks, high 30 clocks (treated as freq=1).
6. Async reset asserted mid-high-phase, between clock edges → pwm_out drops immediately. After release the channel restarts at step 0 with shadows 100/0. Other channels, with distinct settings, show independent periods.
